// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: push-button driven switcher between two PLLVR divider presets.
// Debounces the key, sequences PLL reset and lock qualification on every
// switch, and reports busy / locked / sticky timeout status.
module pll_dyn_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 270000,
    parameter int          RESET_HOLD      = 16,
    parameter int          LOCK_STABLE     = 64,
    parameter int          LOCK_TIMEOUT    = 1048576,
    parameter bit          KEY_INV         = 1'b0,
    parameter int          CFG0_FBDIV      = 9,
    parameter int          CFG0_IDIV       = 2,
    parameter logic [5:0]  CFG0_ODIV       = 6'b111100,
    parameter int          CFG1_FBDIV      = 12,
    parameter int          CFG1_IDIV       = 5,
    parameter logic [5:0]  CFG1_ODIV       = 6'b111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       pll_lock,
    output logic [5:0] fdiv,
    output logic [5:0] idiv,
    output logic [5:0] odiv,
    output logic       pll_reset,
    output logic       sel,
    output logic       busy,
    output logic       locked,
    output logic       err
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HD_W = $clog2(RESET_HOLD + 1);
    localparam int ST_W = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;
    localparam int TO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    // The hold counter is already 0 while reset is asserted, so counting up to
    // RESET_HOLD gives RESET_HOLD high cycles after release and one extra
    // cycle after a switch (the SWITCH->RESET_HOLD entry cycle).
    localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(RESET_HOLD);
    localparam logic [ST_W-1:0] ST_LAST   = ST_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

    // PLL-native encoding: feedback and input dividers are inverted selects.
    localparam logic [5:0] P0_FDIV = ~(6'(CFG0_FBDIV));
    localparam logic [5:0] P0_IDIV = ~(6'(CFG0_IDIV));
    localparam logic [5:0] P1_FDIV = ~(6'(CFG1_FBDIV));
    localparam logic [5:0] P1_IDIV = ~(6'(CFG1_IDIV));

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_WAIT_LOCK,
        S_LOCKED,
        S_ERROR,
        S_SWITCH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_key_m;
    logic            r_key_s;
    logic            r_lock_m;
    logic            r_lock_s;
    logic            r_key_db;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;

    logic [HD_W-1:0] r_hold_cnt;
    logic [ST_W-1:0] r_stable_cnt;
    logic [TO_W-1:0] r_tmo_cnt;

    logic [5:0]      r_fdiv;
    logic [5:0]      r_idiv;
    logic [5:0]      r_odiv;
    logic            r_pll_reset;
    logic            r_sel;
    logic            r_busy;
    logic            r_locked;
    logic            r_err;

    logic            w_key_in;

    assign w_key_in = key ^ KEY_INV;

    // Two-flop synchronisers for the asynchronous key and PLL lock inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_m  <= 1'b0;
            r_key_s  <= 1'b0;
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_key_m  <= w_key_in;
            r_key_s  <= r_key_m;
            r_lock_m <= pll_lock;
            r_lock_s <= r_lock_m;
        end
    end

    // Debounce: accept a new key level after DEBOUNCE_CYCLES consecutive
    // differing samples; emit a one-cycle press on an accepted rising level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_db <= 1'b0;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_key_s == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_key_db <= ~r_key_db;
                r_db_cnt <= '0;
                r_press  <= ~r_key_db;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; lock qualification wins over timeout, lock loss wins
    // over a coincident press, and presses in busy states are simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (r_lock_s && (r_stable_cnt == ST_LAST)) w_state_nxt = S_LOCKED;
                else if (r_tmo_cnt == TO_LAST)             w_state_nxt = S_ERROR;
            end
            S_LOCKED: begin
                if (!r_lock_s)   w_state_nxt = S_WAIT_LOCK;
                else if (r_press) w_state_nxt = S_SWITCH;
            end
            S_ERROR: begin
                if (r_press) w_state_nxt = S_SWITCH;
            end
            S_SWITCH: begin
                w_state_nxt = S_RESET_HOLD;
            end
            default: begin
                w_state_nxt = S_RESET_HOLD;
            end
        endcase
    end

    // Phase counters; each clears whenever its state is entered or left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt   <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            if ((r_state == S_RESET_HOLD) && (w_state_nxt == S_RESET_HOLD))
                r_hold_cnt <= r_hold_cnt + 1'b1;
            else
                r_hold_cnt <= '0;

            if ((r_state == S_WAIT_LOCK) && (w_state_nxt == S_WAIT_LOCK)) begin
                r_stable_cnt <= r_lock_s ? (r_stable_cnt + 1'b1) : '0;
                r_tmo_cnt    <= r_tmo_cnt + 1'b1;
            end else begin
                r_stable_cnt <= '0;
                r_tmo_cnt    <= '0;
            end
        end
    end

    // Registered outputs decoded from the next state; presets load only on
    // entry to SWITCH so dividers settle before the PLL reset pulse begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pll_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_sel       <= 1'b0;
            r_fdiv      <= P0_FDIV;
            r_idiv      <= P0_IDIV;
            r_odiv      <= CFG0_ODIV;
        end else begin
            r_pll_reset <= (w_state_nxt == S_RESET_HOLD);
            r_busy      <= (w_state_nxt == S_RESET_HOLD) || (w_state_nxt == S_WAIT_LOCK);
            r_locked    <= (w_state_nxt == S_LOCKED);
            if (w_state_nxt == S_ERROR)       r_err <= 1'b1;
            else if (w_state_nxt == S_LOCKED) r_err <= 1'b0;
            if (w_state_nxt == S_SWITCH) begin
                r_sel  <= ~r_sel;
                r_fdiv <= r_sel ? P0_FDIV   : P1_FDIV;
                r_idiv <= r_sel ? P0_IDIV   : P1_IDIV;
                r_odiv <= r_sel ? CFG0_ODIV : CFG1_ODIV;
            end
        end
    end

    assign fdiv      = r_fdiv;
    assign idiv      = r_idiv;
    assign odiv      = r_odiv;
    assign pll_reset = r_pll_reset;
    assign sel       = r_sel;
    assign busy      = r_busy;
    assign locked    = r_locked;
    assign err       = r_err;

endmodule
